// File: rtl/regfile_wport_sched_pkg.sv
// Shared types for the register-file write-port scheduler.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package regfile_wport_sched_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int NREG  = 32;

    // One completed long-latency result waiting for the write port.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } ll_entry_t;

    localparam int LL_ENTRY_W = $bits(ll_entry_t);

    // One-hot register mask, used to rebuild the pending vector.
    function automatic logic [NREG-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        logic [NREG-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wport_sched_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and per-slot valid/tag view.
// Latency: pushed entry visible at the head one cycle after the push edge (no bypass).
// Backpressure: caller must gate push with ~full_o and pop with ~empty_o.
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int TAG_W = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    push_i,
    input  logic [WIDTH-1:0]                        push_dat_i,
    input  logic                                    pop_i,
    output logic [WIDTH-1:0]                        head_dat_o,
    output logic [$clog2(DEPTH)-1:0]                head_idx_o,
    output logic                                    full_o,
    output logic                                    empty_o,
    output logic [DEPTH-1:0]                        ent_vld_o,
    output logic [DEPTH-1:0][TAG_W-1:0]             ent_tag_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW:0]                 wr_q, wr_d;
    logic [AW:0]                 rd_q, rd_d;
    logic [AW:0]                 count;
    logic [AW-1:0]               off;

    assign wr_d       = push_i ? wr_q + 1'b1 : wr_q;
    assign rd_d       = pop_i  ? rd_q + 1'b1 : rd_q;
    assign count      = wr_q - rd_q;
    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_idx_o = rd_q[AW-1:0];
    assign head_dat_o = mem_q[rd_q[AW-1:0]];

    // Slot i holds a live entry when its distance from the head is below the occupancy.
    always_comb begin
        ent_vld_o = '0;
        ent_tag_o = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = AW'(i) - rd_q[AW-1:0];
            ent_vld_o[i] = ({1'b0, off} < count);
            ent_tag_o[i] = mem_q[i][WIDTH-1 -: TAG_W];
        end
    end

    // Pointer registers; reset discards every stored entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/regfile_wport_sched.sv
// Shares the single RF write port between write-back (priority) and queued mul/div results.
// Latency: write-back passes combinationally; queued result writes >=1 cycle after its push.
// Backpressure: ll_ready = ~full; w_hold asks upstream for a write-back bubble on starvation.
module regfile_wport_sched
    import regfile_wport_sched_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_wen,
    input  logic [REG_W-1:0] w_rd,
    input  logic [XLEN-1:0]  w_wdata,
    input  logic             ll_valid,
    output logic             ll_ready,
    input  logic [REG_W-1:0] ll_rd,
    input  logic [XLEN-1:0]  ll_wdata,
    input  logic             iss_valid,
    input  logic [REG_W-1:0] iss_rd,
    input  logic             flush,
    input  logic [REG_W-1:0] q_rs1,
    input  logic [REG_W-1:0] q_rs2,
    input  logic [REG_W-1:0] q_rd,
    output logic             hz_rs1,
    output logic             hz_rs2,
    output logic             hz_rd,
    output logic             rf_wen,
    output logic [REG_W-1:0] rf_rd,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             w_hold
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    ll_entry_t                    push_ent;
    logic [LL_ENTRY_W-1:0]        head_dat;
    ll_entry_t                    head;
    logic [AW-1:0]                head_idx;
    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0][REG_W-1:0]  ent_rd;
    logic [NREG-1:0]              flush_map;
    logic [NREG-1:0]              busy_q, busy_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         hold_q, hold_d;
    logic [REG_W-1:0]             sel_rd;

    assign push_ent  = '{rd: ll_rd, data: ll_wdata};
    assign ll_ready  = ~fifo_full;
    assign fifo_push = ll_valid & ~fifo_full;
    assign fifo_pop  = ~w_wen & ~fifo_empty;
    assign head      = ll_entry_t'(head_dat);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LL_ENTRY_W),
        .TAG_W (REG_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (push_ent),
        .pop_i      (fifo_pop),
        .head_dat_o (head_dat),
        .head_idx_o (head_idx),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .ent_vld_o  (ent_vld),
        .ent_tag_o  (ent_rd)
    );

    // Port mux: write-back wins, otherwise the FIFO head; x0 writes are suppressed.
    always_comb begin
        sel_rd   = w_rd;
        rf_wdata = w_wdata;
        if (!w_wen) begin
            sel_rd   = head.rd;
            rf_wdata = head.data;
        end
        rf_rd  = sel_rd;
        rf_wen = (w_wen | ~fifo_empty) & (sel_rd != '0);
    end

    // Pending map of what will still be queued after this edge, for flush recovery.
    always_comb begin
        flush_map = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !(fifo_pop && (head_idx == AW'(i)))) begin
                flush_map = flush_map | rd_onehot(ent_rd[i]);
            end
        end
        if (fifo_push) begin
            flush_map = flush_map | rd_onehot(ll_rd);
        end
    end

    // Scoreboard next state: flush rebuilds; otherwise drain clears and issue sets (set wins).
    always_comb begin
        if (flush) begin
            busy_d = flush_map;
        end else begin
            busy_d = busy_q;
            if (fifo_pop) begin
                busy_d[head.rd] = 1'b0;
            end
            if (iss_valid && (iss_rd != '0)) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Starvation counter: counts queued-but-blocked cycles, fires a one-cycle hold at the limit.
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = 1'b0;
        if (cnt_q == CNT_W'(STARVE_MAX)) begin
            cnt_d  = '0;
            hold_d = 1'b1;
        end else if (fifo_empty || fifo_pop) begin
            cnt_d = '0;
        end else if (w_wen) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign w_hold = hold_q;
    assign hz_rs1 = busy_q[q_rs1] & (q_rs1 != '0);
    assign hz_rs2 = busy_q[q_rs2] & (q_rs2 != '0);
    assign hz_rd  = busy_q[q_rd]  & (q_rd  != '0);

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Bench for regfile_wport_sched: directed scenarios with literal expectations plus random traffic.
// A queue-based reference model is compared against the DUT every cycle.
module tb_regfile_wport_sched;
    import regfile_wport_sched_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_wen, ll_valid, ll_ready, iss_valid, flush;
    logic [4:0]  w_rd, ll_rd, iss_rd, q_rs1, q_rs2, q_rd, rf_rd;
    logic [31:0] w_wdata, ll_wdata, rf_wdata;
    logic        hz_rs1, hz_rs2, hz_rd, rf_wen, w_hold;

    regfile_wport_sched #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .w_wen(w_wen), .w_rd(w_rd), .w_wdata(w_wdata),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_wdata(ll_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .w_hold(w_hold)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    ment_t       popped;
    bit          mbusy[32];
    int          mstarve;
    bit          mhold;
    bit          e_wen, m_pop, m_push, nhold;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    int          sz;

    initial begin
        mstarve = 0;
        mhold   = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                for (int i = 0; i < 32; i++) mbusy[i] = 0;
                mstarve = 0;
                mhold   = 0;
            end
            sz = mq.size();
            e_wen = 0; e_rd = 0; e_dat = 0;
            if (w_wen) begin
                e_rd = w_rd; e_dat = w_wdata; e_wen = (w_rd != 0);
            end else if (sz > 0) begin
                e_rd = mq[0].rd; e_dat = mq[0].data; e_wen = (mq[0].rd != 0);
            end
            chk("m_rf_wen", 32'(rf_wen), 32'(e_wen));
            if (e_wen) begin
                chk("m_rf_rd", 32'(rf_rd), 32'(e_rd));
                chk("m_rf_wdata", rf_wdata, e_dat);
            end
            chk("m_ll_ready", 32'(ll_ready), 32'(sz < DEPTH));
            chk("m_hz_rs1", 32'(hz_rs1), 32'(mbusy[q_rs1] && q_rs1 != 0));
            chk("m_hz_rs2", 32'(hz_rs2), 32'(mbusy[q_rs2] && q_rs2 != 0));
            chk("m_hz_rd", 32'(hz_rd), 32'(mbusy[q_rd] && q_rd != 0));
            chk("m_w_hold", 32'(w_hold), 32'(mhold));
            if (rst) begin
                m_pop  = !w_wen && sz > 0;
                m_push = ll_valid && sz < DEPTH;
                nhold  = 0;
                if (mstarve == SMAX) begin
                    nhold = 1; mstarve = 0;
                end else if (sz == 0 || m_pop) begin
                    mstarve = 0;
                end else if (w_wen) begin
                    mstarve++;
                end
                mhold = nhold;
                if (m_pop) popped = mq.pop_front();
                if (m_push) mq.push_back('{rd: ll_rd, data: ll_wdata});
                if (flush) begin
                    for (int i = 0; i < 32; i++) mbusy[i] = 0;
                    foreach (mq[i]) mbusy[mq[i].rd] = 1;
                end else begin
                    if (m_pop) mbusy[popped.rd] = 0;
                    if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1;
                end
                mbusy[0] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #2;
        w_wen = 0; ll_valid = 0; iss_valid = 0; flush = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    int  holds;
    bit  bubble, hb;

    initial begin
        rst = 0; w_wen = 0; w_rd = 0; w_wdata = 0; ll_valid = 0; ll_rd = 0; ll_wdata = 0;
        iss_valid = 0; iss_rd = 0; flush = 0; q_rs1 = 0; q_rs2 = 0; q_rd = 0;

        // reset state
        sample();
        chk("rst_ll_ready", 32'(ll_ready), 32'd1);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_w_hold", 32'(w_hold), 32'd0);
        nxt(); rst = 1;

        // write-back only
        nxt(); w_wen = 1; w_rd = 5; w_wdata = 32'hA5;
        sample();
        chk("wb_wen", 32'(rf_wen), 32'd1);
        chk("wb_rd", 32'(rf_rd), 32'd5);
        chk("wb_data", rf_wdata, 32'hA5);

        // queued drain
        nxt(); iss_valid = 1; iss_rd = 7; q_rd = 7;
        sample(); chk("qd_hz_issue_cycle", 32'(hz_rd), 32'd0);
        nxt(); w_wen = 1; w_rd = 1; w_wdata = 32'h11; ll_valid = 1; ll_rd = 7; ll_wdata = 32'h1234;
        sample(); chk("qd_hz_push", 32'(hz_rd), 32'd1); chk("qd_wb_rd", 32'(rf_rd), 32'd1);
        for (int c = 0; c < 2; c++) begin
            nxt(); w_wen = 1; w_rd = 2;
            sample(); chk("qd_hz_hold", 32'(hz_rd), 32'd1); chk("qd_wb_rd2", 32'(rf_rd), 32'd2);
        end
        nxt();
        sample();
        chk("qd_drain_wen", 32'(rf_wen), 32'd1);
        chk("qd_drain_rd", 32'(rf_rd), 32'd7);
        chk("qd_drain_data", rf_wdata, 32'h1234);
        chk("qd_hz_drain_cycle", 32'(hz_rd), 32'd1);
        nxt(); sample(); chk("qd_hz_after", 32'(hz_rd), 32'd0); chk("qd_idle", 32'(rf_wen), 32'd0);

        // full and pointer wrap
        nxt(); w_wen = 1; w_rd = 1; ll_valid = 1; ll_rd = 10; ll_wdata = 32'h100;
        nxt(); w_wen = 1; ll_valid = 1; ll_rd = 11; ll_wdata = 32'h101;
        nxt(); w_wen = 1; sample(); chk("full_ready", 32'(ll_ready), 32'd0);
        nxt(); ll_valid = 1; ll_rd = 30; ll_wdata = 32'h1FF;
        sample();
        chk("full_pop_ready", 32'(ll_ready), 32'd0);
        chk("full_head", rf_wdata, 32'h100);
        for (int k = 0; k < 6; k++) begin
            nxt(); ll_valid = 1; ll_rd = 5'(12 + k); ll_wdata = 32'h200 + 32'(k);
            sample();
            chk("wrap_ready", 32'(ll_ready), 32'd1);
            chk("wrap_data", rf_wdata, (k == 0) ? 32'h101 : 32'h200 + 32'(k - 1));
            chk("wrap_rd", 32'(rf_rd), (k == 0) ? 32'd11 : 32'(11 + k));
        end
        nxt(); sample(); chk("wrap_last", rf_wdata, 32'h205); chk("wrap_last_rd", 32'(rf_rd), 32'd17);
        nxt(); sample(); chk("wrap_empty", 32'(rf_wen), 32'd0);

        // starvation
        nxt(); w_wen = 1; w_rd = 1; ll_valid = 1; ll_rd = 4; ll_wdata = 32'h44;
        sample(); chk("starve_c0", 32'(w_hold), 32'd0);
        holds = 0;
        for (int c = 1; c <= 8; c++) begin
            nxt(); w_wen = 1; sample(); holds += int'(w_hold);
        end
        chk("starve_early_holds", 32'(holds), 32'd0);
        nxt(); w_wen = 1; sample(); chk("starve_hold", 32'(w_hold), 32'd1);
        nxt(); sample();
        chk("starve_hold_drop", 32'(w_hold), 32'd0);
        chk("starve_drain_rd", 32'(rf_rd), 32'd4);
        chk("starve_drain_data", rf_wdata, 32'h44);
        holds = 0;
        for (int c = 0; c < 10; c++) begin
            nxt(); w_wen = 1; sample(); holds += int'(w_hold);
        end
        chk("starve_empty_holds", 32'(holds), 32'd0);

        // flush
        nxt(); iss_valid = 1; iss_rd = 3; q_rs1 = 3; q_rs2 = 9;
        nxt(); iss_valid = 1; iss_rd = 9; w_wen = 1; ll_valid = 1; ll_rd = 3; ll_wdata = 32'h33;
        sample(); chk("fl_hz3_pre", 32'(hz_rs1), 32'd1); chk("fl_hz9_pre", 32'(hz_rs2), 32'd0);
        nxt(); w_wen = 1; flush = 1;
        sample(); chk("fl_hz3_at", 32'(hz_rs1), 32'd1); chk("fl_hz9_at", 32'(hz_rs2), 32'd1);
        nxt(); w_wen = 1;
        sample(); chk("fl_hz3_after", 32'(hz_rs1), 32'd1); chk("fl_hz9_after", 32'(hz_rs2), 32'd0);
        nxt(); sample(); chk("fl_drain_rd", 32'(rf_rd), 32'd3); chk("fl_hz3_drain", 32'(hz_rs1), 32'd1);
        nxt(); sample(); chk("fl_hz3_clear", 32'(hz_rs1), 32'd0);

        // x0 handling
        nxt(); iss_valid = 1; iss_rd = 0; q_rd = 0; w_wen = 1; ll_valid = 1; ll_rd = 0; ll_wdata = 32'h55;
        nxt(); w_wen = 1; ll_valid = 1; ll_rd = 6; ll_wdata = 32'h66;
        sample(); chk("x0_hz", 32'(hz_rd), 32'd0);
        nxt(); sample(); chk("x0_pop_wen", 32'(rf_wen), 32'd0);
        nxt(); sample(); chk("x0_next_wen", 32'(rf_wen), 32'd1); chk("x0_next_rd", 32'(rf_rd), 32'd6);

        // asynchronous reset mid-queue
        nxt(); iss_valid = 1; iss_rd = 20; q_rd = 20; w_wen = 1; ll_valid = 1; ll_rd = 20; ll_wdata = 32'h1;
        nxt(); w_wen = 1; ll_valid = 1; ll_rd = 21; ll_wdata = 32'h2;
        nxt(); w_wen = 1; sample(); chk("ar_full", 32'(ll_ready), 32'd0); chk("ar_hz_pre", 32'(hz_rd), 32'd1);
        nxt(); rst = 0;
        #1;
        chk("ar_ready_now", 32'(ll_ready), 32'd1);
        chk("ar_hz_now", 32'(hz_rd), 32'd0);
        sample(); chk("ar_rf_wen", 32'(rf_wen), 32'd0);
        nxt(); rst = 1; sample(); chk("ar_empty", 32'(rf_wen), 32'd0);

        // randomized traffic
        bubble = 0;
        for (int n = 0; n < 3000; n++) begin
            nxt();
            hb     = bubble;
            bubble = w_hold;
            rst       = ($urandom_range(0, 499) != 0);
            w_wen     = hb ? 1'b0 : ($urandom_range(0, 99) < 60);
            w_rd      = 5'($urandom_range(0, 7));
            w_wdata   = $urandom;
            ll_valid  = ($urandom_range(0, 99) < 40);
            ll_rd     = 5'($urandom_range(0, 7));
            ll_wdata  = $urandom;
            iss_valid = ($urandom_range(0, 99) < 25);
            iss_rd    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 99) < 3);
            q_rs1     = 5'($urandom_range(0, 7));
            q_rs2     = 5'($urandom_range(0, 7));
            q_rd      = 5'($urandom_range(0, 7));
        end
        nxt(); rst = 1;
        sample();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
